// File: rtl/set_assoc_cache_pkg.sv
// Shared types and address-field width helpers for the 2-way set-associative cache.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REFILL_REQ,
    REFILL_DATA,
    WRITE_MEM,
    RESP
  } cache_state_e;

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int offset_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int tag_w(input int sets, input int words_per_line);
    return 32 - 2 - index_w(sets) - offset_w(words_per_line);
  endfunction

endpackage

// File: rtl/set_assoc_cache_if.sv
// CPU load/store port and memory refill/write port of the cache, bundled as one interface.
interface set_assoc_cache_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [31:0]           req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_we;
  logic [31:0]           mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_req_ready, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, mem_req_valid, mem_req_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_req_ready, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, mem_req_valid, mem_req_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/set_assoc_cache_way.sv
// One way of the cache: valid/tag/data arrays with combinational lookup and a single write port.
module cache_way
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int SETS           = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int TAG_W          = 25,
  parameter int IDX_B          = 3,
  parameter int OFF_B          = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IDX_B-1:0]      lk_idx,
  input  logic [TAG_W-1:0]      lk_tag,
  input  logic [OFF_B-1:0]      lk_off,
  output logic                  lk_hit,
  output logic                  lk_valid,
  output logic [DATA_WIDTH-1:0] lk_data,
  input  logic                  wr_en,
  input  logic [IDX_B-1:0]      wr_idx,
  input  logic [OFF_B-1:0]      wr_off,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  set_en,
  input  logic [TAG_W-1:0]      set_tag,
  input  logic                  inv_en,
  input  logic                  flush_all
);
  logic [SETS-1:0]       valid_q;
  logic [TAG_W-1:0]      tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS][WORDS_PER_LINE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush_all) begin
      valid_q <= '0;
    end else if (set_en) begin
      valid_q[wr_idx] <= 1'b1;
    end else if (inv_en) begin
      valid_q[wr_idx] <= 1'b0;
    end
  end

  // Payload arrays need no reset: every read is qualified by valid_q.
  always_ff @(posedge clk) begin
    if (wr_en)  data_q[wr_idx][wr_off] <= wr_data;
    if (set_en) tag_q[wr_idx]          <= set_tag;
  end

  assign lk_valid = valid_q[lk_idx];
  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_data  = data_q[lk_idx][lk_off];

endmodule

// File: rtl/set_assoc_cache.sv
// 2-way set-associative write-through, no-write-allocate cache with burst refill and 1-bit LRU.
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
//   state       | meaning
//   IDLE        | accept CPU request or flush, tag compare both ways
//   REFILL_REQ  | line read request pending on memory port
//   REFILL_DATA | collecting refill beats into the victim way
//   WRITE_MEM   | single-word write-through pending on memory port
//   RESP        | one-cycle response pulse to the CPU
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int SETS           = 8,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  set_assoc_cache_if.slave       bus,
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count
);
  localparam int INDEX_W  = index_w(SETS);
  localparam int OFFSET_W = offset_w(WORDS_PER_LINE);
  localparam int TAG_W    = tag_w(SETS, WORDS_PER_LINE);
  localparam int IDX_B    = (INDEX_W > 0) ? INDEX_W : 1;
  localparam int OFF_B    = (OFFSET_W > 0) ? OFFSET_W : 1;

  // Field extraction by shift/mask keeps zero-width fields (1 set or 1 word) legal.
  function automatic logic [IDX_B-1:0] addr_idx(input logic [31:0] a);
    return IDX_B'((a >> (2 + OFFSET_W)) & 32'(SETS - 1));
  endfunction
  function automatic logic [OFF_B-1:0] addr_off(input logic [31:0] a);
    return OFF_B'((a >> 2) & 32'(WORDS_PER_LINE - 1));
  endfunction
  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return TAG_W'(a >> (2 + OFFSET_W + INDEX_W));
  endfunction

  cache_state_e          state_q;
  logic [31:0]           addr_q;
  logic                  way_q;
  logic [OFF_B-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] cap_q;
  logic [SETS-1:0]       lru_q;

  logic [IDX_B-1:0]      req_idx, idx_q, wr_idx;
  logic [OFF_B-1:0]      req_off, off_q, wr_off;
  logic [TAG_W-1:0]      req_tag, set_tag;
  logic [1:0]            hit, vld, wr_en, set_en, inv_en;
  logic [DATA_WIDTH-1:0] rd [2];
  logic [DATA_WIDTH-1:0] wr_data, hit_data;
  logic                  accept, any_hit, hit_way, victim, last_beat, flush_all;

  assign req_idx   = addr_idx(bus.req_addr);
  assign req_off   = addr_off(bus.req_addr);
  assign req_tag   = addr_tag(bus.req_addr);
  assign idx_q     = addr_idx(addr_q);
  assign off_q     = addr_off(addr_q);
  assign set_tag   = addr_tag(addr_q);
  assign bus.req_ready = (state_q == IDLE) && !flush;
  assign accept    = (state_q == IDLE) && !flush && bus.req_valid;
  assign flush_all = (state_q == IDLE) && flush;
  assign any_hit   = |hit;
  assign hit_way   = ~hit[0];
  assign hit_data  = hit[0] ? rd[0] : rd[1];
  assign victim    = !vld[0] ? 1'b0 : (!vld[1] ? 1'b1 : lru_q[req_idx]);
  assign last_beat = (cnt_q == OFF_B'(WORDS_PER_LINE - 1));

  for (genvar w = 0; w < 2; w++) begin : g_way
    cache_way #(
      .DATA_WIDTH(DATA_WIDTH), .SETS(SETS), .WORDS_PER_LINE(WORDS_PER_LINE),
      .TAG_W(TAG_W), .IDX_B(IDX_B), .OFF_B(OFF_B)
    ) u_way (
      .clk(clk), .rst_n(rst_n),
      .lk_idx(req_idx), .lk_tag(req_tag), .lk_off(req_off),
      .lk_hit(hit[w]), .lk_valid(vld[w]), .lk_data(rd[w]),
      .wr_en(wr_en[w]), .wr_idx(wr_idx), .wr_off(wr_off), .wr_data(wr_data),
      .set_en(set_en[w]), .set_tag(set_tag), .inv_en(inv_en[w]), .flush_all(flush_all)
    );
  end

  // Victim is invalidated at miss accept so an interrupted refill never leaves a stale line.
  always_comb begin
    wr_en   = '0;
    set_en  = '0;
    inv_en  = '0;
    wr_idx  = req_idx;
    wr_off  = req_off;
    wr_data = bus.req_wdata;
    if (accept) begin
      if (bus.req_we) wr_en = hit;
      else if (!any_hit) inv_en[victim] = 1'b1;
    end else if (state_q == REFILL_DATA && bus.mem_rvalid) begin
      wr_idx         = idx_q;
      wr_off         = cnt_q;
      wr_data        = bus.mem_rdata;
      wr_en[way_q]   = 1'b1;
      set_en[way_q]  = last_beat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      addr_q            <= '0;
      way_q             <= 1'b0;
      cnt_q             <= '0;
      cap_q             <= '0;
      lru_q             <= '0;
      bus.resp_valid    <= 1'b0;
      bus.resp_rdata    <= '0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_req_we    <= 1'b0;
      bus.mem_addr      <= '0;
      bus.mem_wdata     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush) begin
            lru_q <= '0;
          end else if (bus.req_valid) begin
            addr_q <= bus.req_addr;
            if (bus.req_we) begin
              if (any_hit) lru_q[req_idx] <= ~hit_way;
              bus.mem_req_valid <= 1'b1;
              bus.mem_req_we    <= 1'b1;
              bus.mem_addr      <= bus.req_addr & ~32'd3;
              bus.mem_wdata     <= bus.req_wdata;
              state_q           <= WRITE_MEM;
            end else if (any_hit) begin
              lru_q[req_idx] <= ~hit_way;
              bus.resp_valid <= 1'b1;
              bus.resp_rdata <= hit_data;
              state_q        <= RESP;
            end else begin
              way_q             <= victim;
              bus.mem_req_valid <= 1'b1;
              bus.mem_req_we    <= 1'b0;
              bus.mem_addr      <= bus.req_addr & ~32'((WORDS_PER_LINE * 4) - 1);
              state_q           <= REFILL_REQ;
            end
          end
        end
        REFILL_REQ: begin
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            cnt_q             <= '0;
            state_q           <= REFILL_DATA;
          end
        end
        REFILL_DATA: begin
          if (bus.mem_rvalid) begin
            if (cnt_q == off_q) cap_q <= bus.mem_rdata;
            if (last_beat) begin
              lru_q[idx_q]   <= ~way_q;
              bus.resp_valid <= 1'b1;
              bus.resp_rdata <= (cnt_q == off_q) ? bus.mem_rdata : cap_q;
              state_q        <= RESP;
            end else begin
              cnt_q <= cnt_q + OFF_B'(1);
            end
          end
        end
        WRITE_MEM: begin
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            bus.resp_valid    <= 1'b1;
            bus.resp_rdata    <= '0;
            state_q           <= RESP;
          end
        end
        RESP: begin
          bus.resp_valid <= 1'b0;
          bus.resp_rdata <= '0;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (accept) begin
      if (any_hit) begin
        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// Randomized bench for set_assoc_cache against a recency-list cache model and a flat memory model.
module tb_set_assoc_cache;
  localparam int WPL = 4;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [31:0] hit_count, miss_count;

  set_assoc_cache_if #(.DATA_WIDTH(32)) bus ();

  set_assoc_cache #(.DATA_WIDTH(32), .SETS(8), .WORDS_PER_LINE(WPL)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  bit tb_idle = 1'b0;

  // Model: per set, most- and least-recently used line tags and how many lines are held.
  logic [24:0] mru_tag [8];
  logic [24:0] lru_tag [8];
  int          ncnt    [8];
  int          exp_hits, exp_misses;
  logic [31:0] refmem [logic [31:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (refmem.exists(a)) return refmem[a];
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < 8; s++) ncnt[s] = 0;
  endfunction

  function automatic bit model_access(input bit we, input logic [31:0] a);
    int          s;
    logic [24:0] t;
    bit          h;
    s = int'((a >> 4) & 32'd7);
    t = 25'(a >> 7);
    h = (ncnt[s] >= 1 && mru_tag[s] == t) || (ncnt[s] == 2 && lru_tag[s] == t);
    if (h) begin
      if (mru_tag[s] != t) begin
        lru_tag[s] = mru_tag[s];
        mru_tag[s] = t;
      end
    end else if (!we) begin
      if (ncnt[s] > 0) lru_tag[s] = mru_tag[s];
      mru_tag[s] = t;
      if (ncnt[s] < 2) ncnt[s]++;
    end
    if (h) exp_hits++;
    else exp_misses++;
    return h;
  endfunction

  task automatic check_counters();
`ifdef CACHE_STATS_EN
    check("hit_count", hit_count, 32'(exp_hits));
    check("miss_count", miss_count, 32'(exp_misses));
`else
    check("hit_count", hit_count, 32'd0);
    check("miss_count", miss_count, 32'd0);
`endif
  endtask

  // Idle-time monitor: no response or memory traffic without an outstanding request.
  initial begin
    forever begin
      @(negedge clk);
      if (tb_idle && rst_n) begin
        check("idle_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("idle_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
      end
    end
  end

  // One CPU request, serving the memory port with random stalls and checking every cycle.
  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input bit with_flush, input int abort_beats,
                        output bit saw_hit, output logic [31:0] rdata);
    logic [31:0] waddr, base, exp_rd;
    bit          exp_hit, got_mem, in_burst, done;
    int          cyc, beat;
    waddr   = addr & ~32'd3;
    base    = addr & ~32'hF;
    saw_hit = 1'b0;
    rdata   = '0;
    tb_idle = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    if (with_flush) begin
      flush = 1'b1;
      @(negedge clk);
      check("flush_blocks_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      model_clear();
    end
    @(negedge clk);
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    exp_rd  = ref_rd(waddr);
    exp_hit = model_access(we, addr);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    cyc = 0; beat = 0; got_mem = 1'b0; in_burst = 1'b0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      bus.mem_req_ready = 1'b0;
      bus.mem_rvalid    = 1'b0;
      if (cyc > 100) begin
        n_vec++;
        n_err++;
        $display("FAIL timeout: no response after %0d cycles, required within 100", cyc);
        done = 1'b1;
      end else if (bus.resp_valid) begin
        saw_hit = !got_mem && (cyc == 1);
        rdata   = bus.resp_rdata;
        check("resp_rdata", bus.resp_rdata, we ? 32'd0 : exp_rd);
        if (we || !exp_hit) check("mem_used", 32'(got_mem), 32'd1);
        if (!we && !exp_hit) check("refill_beats", 32'(beat), 32'(WPL));
        if (!we && exp_hit) check("hit_latency", 32'(cyc), 32'd1);
        done = 1'b1;
      end else if (in_burst) begin
        if (abort_beats != 0 && beat == abort_beats) begin
          rst_n = 1'b0;
          #1;
          check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
          check("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
          check("rst_req_ready", 32'(bus.req_ready), 32'd1);
          model_clear();
          exp_hits   = 0;
          exp_misses = 0;
          @(posedge clk); #2;
          rst_n = 1'b1;
          done  = 1'b1;
        end else if (beat < WPL && $urandom_range(0, 3) != 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = ref_rd(base + 32'(4 * beat));
          beat++;
        end
      end else if (bus.mem_req_valid) begin
        got_mem = 1'b1;
        check("mem_req_we", 32'(bus.mem_req_we), 32'(we));
        check("mem_addr", bus.mem_addr, we ? waddr : base);
        if (we) check("mem_wdata", bus.mem_wdata, wd);
        if ($urandom_range(0, 2) != 0) begin
          bus.mem_req_ready = 1'b1;
          if (we) refmem[waddr] = wd;
          else in_burst = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    bus.mem_rvalid    = 1'b0;
    check_counters();
    tb_idle = 1'b1;
  endtask

  logic [31:0] t4_addr [6];
  bit          t4_hit  [6];
  bit          h;
  logic [31:0] rd, a;

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_req_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    model_clear();
    exp_hits = 0;
    exp_misses = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset_req_ready", 32'(bus.req_ready), 32'd1);
    check("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("reset_resp_rdata", bus.resp_rdata, 32'd0);
    check("reset_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check_counters();
    tb_idle = 1'b1;

    // LRU sequence on set 0, expected pattern written out by hand.
    t4_addr = '{32'h000, 32'h080, 32'h000, 32'h100, 32'h000, 32'h080};
    t4_hit  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      do_req(1'b0, t4_addr[i], 32'd0, 1'b0, 0, h, rd);
      check("lru_seq_hit", 32'(h), 32'(t4_hit[i]));
    end
`ifdef CACHE_STATS_EN
    check("stats_hits_lit", hit_count, 32'd2);
    check("stats_misses_lit", miss_count, 32'd4);
`endif

    // Flush racing a load: the load must miss afterwards.
    do_req(1'b0, 32'h000, 32'd0, 1'b1, 0, h, rd);
    check("flush_then_miss", 32'(h), 32'd0);

    // Cold line refill returns the offset word; neighbour word then hits.
    refmem[32'h40] = 32'hA0A0_0000;
    refmem[32'h44] = 32'hA0A0_0001;
    refmem[32'h48] = 32'hA0A0_0002;
    refmem[32'h4C] = 32'hA0A0_0003;
    do_req(1'b0, 32'h44, 32'd0, 1'b0, 0, h, rd);
    check("cold_miss", 32'(h), 32'd0);
    check("cold_word1", rd, 32'hA0A0_0001);
    do_req(1'b0, 32'h48, 32'd0, 1'b0, 0, h, rd);
    check("warm_hit", 32'(h), 32'd1);
    check("warm_word2", rd, 32'hA0A0_0002);

    // Store hit updates cache; store miss does not allocate.
    do_req(1'b1, 32'h44, 32'h0000_DEAD, 1'b0, 0, h, rd);
    do_req(1'b0, 32'h44, 32'd0, 1'b0, 0, h, rd);
    check("store_hit_reload_hit", 32'(h), 32'd1);
    check("store_hit_data", rd, 32'h0000_DEAD);
    do_req(1'b1, 32'h200, 32'h0000_BEEF, 1'b0, 0, h, rd);
    do_req(1'b0, 32'h200, 32'd0, 1'b0, 0, h, rd);
    check("no_write_allocate", 32'(h), 32'd0);
    check("store_miss_data", rd, 32'h0000_BEEF);

    // Reset after two refill beats, then a stray beat while idle.
    do_req(1'b0, 32'h300, 32'd0, 1'b0, 2, h, rd);
    @(negedge clk);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hBAD0_BAD0;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    do_req(1'b0, 32'h300, 32'd0, 1'b0, 0, h, rd);
    check("after_reset_miss", 32'(h), 32'd0);

    // Random traffic concentrated on two sets to force evictions.
    for (int i = 0; i < 250; i++) begin
      a = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 1)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
      do_req($urandom_range(0, 9) < 3, a, $urandom, $urandom_range(0, 19) == 0, 0, h, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
